// File: rtl/reg_file_sb_if.sv
`default_nettype none
// ============================================================================
//  Module   : reg_file_sb_if
//  Purpose  : Bundles the writeback, decode-read and issue signals of the
//             scoreboarded register file into a single interface.
//  Ports    : ruu_rwe/ruu_rd/ruu_rdata   writeback into the GPR file
//             rs1_addr/rs2_addr          decode read indices
//             rs1_data/rs2_data          decode read data (combinational)
//             iss_valid/iss_we/iss_rd    issue request from decode
//             iss_ready/hazard           issue acceptance / RAW hazard
//  Modports : slave  - register file side
//             master - pipeline (writeback + decode) side
//  Revision : 1.0 - initial release
// ============================================================================
interface reg_file_sb_if #(
    parameter int REG_WIDTH = 32,
    parameter int NUM_REGS  = 32
);
    localparam int AW = $clog2(NUM_REGS);

    logic                 ruu_rwe;
    logic [AW-1:0]        ruu_rd;
    logic [REG_WIDTH-1:0] ruu_rdata;
    logic [AW-1:0]        rs1_addr;
    logic [AW-1:0]        rs2_addr;
    logic [REG_WIDTH-1:0] rs1_data;
    logic [REG_WIDTH-1:0] rs2_data;
    logic                 iss_valid;
    logic                 iss_we;
    logic [AW-1:0]        iss_rd;
    logic                 iss_ready;
    logic                 hazard;

    modport slave (
        input  ruu_rwe, ruu_rd, ruu_rdata,
        input  rs1_addr, rs2_addr,
        output rs1_data, rs2_data,
        input  iss_valid, iss_we, iss_rd,
        output iss_ready, hazard
    );

    modport master (
        output ruu_rwe, ruu_rd, ruu_rdata,
        output rs1_addr, rs2_addr,
        input  rs1_data, rs2_data,
        output iss_valid, iss_we, iss_rd,
        input  iss_ready, hazard
    );
endinterface
`default_nettype wire

// File: rtl/reg_file_sb.sv
`default_nettype none
// ============================================================================
//  Module   : reg_file_sb
//  Purpose  : RV32I architectural register file with a per-register
//             pending-write scoreboard. Writeback updates the GPRs and retires
//             pending writes; decode reads two registers asynchronously and
//             issues instructions, which are held off on RAW hazards or when
//             the destination's pending counter is saturated.
//  Ports    : clk  - clock, all state changes on posedge
//             rst  - synchronous reset, active-high
//             bus  - reg_file_sb_if.slave (writeback, read ports, issue)
//  Options  : WB_BYPASS_EN - when defined, a writeback in the current cycle is
//             forwarded to matching read ports, and the hazard for a register
//             whose only outstanding write retires this cycle is suppressed.
//  Revision : 1.0 - initial release
// ============================================================================
module reg_file_sb #(
    parameter int REG_WIDTH  = 32,
    parameter int NUM_REGS   = 32,
    parameter int PEND_WIDTH = 2
) (
    input  logic          clk,
    input  logic          rst,
    reg_file_sb_if.slave  bus
);
    localparam int AW = $clog2(NUM_REGS);
    localparam logic [PEND_WIDTH-1:0] c_PEND_MAX = {PEND_WIDTH{1'b1}};
    localparam logic [PEND_WIDTH-1:0] c_PEND_ONE = PEND_WIDTH'(1);

    logic [REG_WIDTH-1:0]  r_gpr  [NUM_REGS];
    logic [PEND_WIDTH-1:0] r_pend [NUM_REGS];

    logic                  w_wb_en;
    logic                  w_iss_full;
    logic                  w_iss_ready;
    logic                  w_iss_acc;
    logic                  w_iss_inc_en;
    logic                  w_rs1_busy;
    logic                  w_rs2_busy;
    logic                  w_hazard;
    logic [PEND_WIDTH-1:0] w_rs1_pend;
    logic [PEND_WIDTH-1:0] w_rs2_pend;
    logic [PEND_WIDTH-1:0] w_iss_pend;
    logic [REG_WIDTH-1:0]  w_rs1_data;
    logic [REG_WIDTH-1:0]  w_rs2_data;
    logic [NUM_REGS-1:0]   w_inc;
    logic [NUM_REGS-1:0]   w_dec;

    // Writes to x0 neither change data nor retire anything.
    assign w_wb_en    = bus.ruu_rwe && (bus.ruu_rd != '0);

    assign w_rs1_pend = r_pend[bus.rs1_addr];
    assign w_rs2_pend = r_pend[bus.rs2_addr];
    assign w_iss_pend = r_pend[bus.iss_rd];

`ifdef WB_BYPASS_EN
    logic w_rs1_fwd;
    logic w_rs2_fwd;

    assign w_rs1_fwd  = w_wb_en && (bus.ruu_rd == bus.rs1_addr);
    assign w_rs2_fwd  = w_wb_en && (bus.ruu_rd == bus.rs2_addr);

    // A reader is only released early when the retiring write is the last
    // one outstanding; with more in flight the forwarded value is stale.
    assign w_rs1_busy = (bus.rs1_addr != '0) && (w_rs1_pend != '0) &&
                        !(w_rs1_fwd && (w_rs1_pend == c_PEND_ONE));
    assign w_rs2_busy = (bus.rs2_addr != '0) && (w_rs2_pend != '0) &&
                        !(w_rs2_fwd && (w_rs2_pend == c_PEND_ONE));

    assign w_rs1_data = (bus.rs1_addr == '0) ? '0 :
                        w_rs1_fwd ? bus.ruu_rdata : r_gpr[bus.rs1_addr];
    assign w_rs2_data = (bus.rs2_addr == '0) ? '0 :
                        w_rs2_fwd ? bus.ruu_rdata : r_gpr[bus.rs2_addr];
`else
    assign w_rs1_busy = (bus.rs1_addr != '0) && (w_rs1_pend != '0);
    assign w_rs2_busy = (bus.rs2_addr != '0) && (w_rs2_pend != '0);

    assign w_rs1_data = (bus.rs1_addr == '0) ? '0 : r_gpr[bus.rs1_addr];
    assign w_rs2_data = (bus.rs2_addr == '0) ? '0 : r_gpr[bus.rs2_addr];
`endif

    assign w_hazard     = w_rs1_busy || w_rs2_busy;

    // A saturated counter cannot take another in-flight write.
    assign w_iss_full   = bus.iss_we && (bus.iss_rd != '0) &&
                          (w_iss_pend == c_PEND_MAX);
    assign w_iss_ready  = !w_hazard && !w_iss_full;
    assign w_iss_acc    = bus.iss_valid && w_iss_ready;
    assign w_iss_inc_en = w_iss_acc && bus.iss_we && (bus.iss_rd != '0);

    // One-hot increment/decrement requests per register. Index 0 never gets
    // a request because both enables already exclude x0.
    always_comb begin
        w_inc = '0;
        w_dec = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            w_inc[i] = w_iss_inc_en && (bus.iss_rd == AW'(i));
            w_dec[i] = w_wb_en && (bus.ruu_rd == AW'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_gpr[i]  <= '0;
                r_pend[i] <= '0;
            end
        end else begin
            if (w_wb_en) begin
                r_gpr[bus.ruu_rd] <= bus.ruu_rdata;
            end
            // Issue and writeback to the same register cancel out. A
            // writeback with nothing pending leaves the counter at zero.
            for (int i = 0; i < NUM_REGS; i++) begin
                if (w_inc[i] && !w_dec[i]) begin
                    r_pend[i] <= r_pend[i] + c_PEND_ONE;
                end else if (w_dec[i] && !w_inc[i] && (r_pend[i] != '0)) begin
                    r_pend[i] <= r_pend[i] - c_PEND_ONE;
                end
            end
        end
    end

    assign bus.rs1_data  = w_rs1_data;
    assign bus.rs2_data  = w_rs2_data;
    assign bus.iss_ready = w_iss_ready;
    assign bus.hazard    = w_hazard;

endmodule
`default_nettype wire

// File: tb/tb_reg_file_sb.sv
`default_nettype none
// ============================================================================
//  Module   : tb_reg_file_sb
//  Purpose  : Self-checking bench for reg_file_sb. A table of directed
//             vectors walks reset, writes, x0, hazards, counter saturation,
//             same-cycle issue/writeback and reset-over-traffic; a random
//             phase then compares every cycle against a register/counter
//             model kept as plain integer arrays.
//  Options  : WB_BYPASS_EN - selects the forwarding expectations.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_reg_file_sb;
    localparam int RW   = 32;
    localparam int NR   = 32;
    localparam int PW   = 2;
    localparam int AW   = 5;
    localparam int PMAX = (1 << PW) - 1;
`ifdef WB_BYPASS_EN
    localparam bit c_BYP = 1'b1;
`else
    localparam bit c_BYP = 1'b0;
`endif

    logic clk;
    logic rst;

    reg_file_sb_if #(.REG_WIDTH(RW), .NUM_REGS(NR)) bus ();

    reg_file_sb #(
        .REG_WIDTH  (RW),
        .NUM_REGS   (NR),
        .PEND_WIDTH (PW)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        bit          chk;
        bit          rst;
        bit          rwe;
        int          rd;
        logic [31:0] rdata;
        int          rs1;
        int          rs2;
        bit          iv;
        bit          iwe;
        int          ird;
        logic [31:0] e_rs1;
        logic [31:0] e_rs2;
        bit          e_haz;
        bit          e_rdy;
    } vec_t;

    vec_t vt[$];

    int errors = 0;
    int checks = 0;

    // Reference state: architectural registers and in-flight write counts.
    logic [31:0] m_gpr  [NR];
    int          m_pend [NR];

    function automatic vec_t mk(bit chk, bit r, bit rwe, int rd, logic [31:0] rdata,
                                int rs1, int rs2, bit iv, bit iwe, int ird,
                                logic [31:0] e1, logic [31:0] e2, bit eh, bit er);
        vec_t v;
        v.chk = chk;  v.rst = r;    v.rwe = rwe; v.rd = rd;   v.rdata = rdata;
        v.rs1 = rs1;  v.rs2 = rs2;  v.iv = iv;   v.iwe = iwe; v.ird = ird;
        v.e_rs1 = e1; v.e_rs2 = e2; v.e_haz = eh; v.e_rdy = er;
        return v;
    endfunction

    task automatic drive(bit r, bit rwe, int rd, logic [31:0] d, int rs1, int rs2,
                         bit iv, bit iwe, int ird);
        rst           = r;
        bus.ruu_rwe   = rwe;
        bus.ruu_rd    = AW'(rd);
        bus.ruu_rdata = d;
        bus.rs1_addr  = AW'(rs1);
        bus.rs2_addr  = AW'(rs2);
        bus.iss_valid = iv;
        bus.iss_we    = iwe;
        bus.iss_rd    = AW'(ird);
    endtask

    task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic bit wb_to(int a);
        return bus.ruu_rwe && (int'(bus.ruu_rd) != 0) && (int'(bus.ruu_rd) == a);
    endfunction

    function automatic logic [31:0] m_read(int a);
        if (a == 0) return 32'h0;
        if (c_BYP && wb_to(a)) return bus.ruu_rdata;
        return m_gpr[a];
    endfunction

    function automatic bit m_busy(int a);
        if (a == 0 || m_pend[a] == 0) return 1'b0;
        if (c_BYP && wb_to(a) && m_pend[a] == 1) return 1'b0;
        return 1'b1;
    endfunction

    function automatic bit m_haz();
        return m_busy(int'(bus.rs1_addr)) || m_busy(int'(bus.rs2_addr));
    endfunction

    function automatic bit m_ready();
        int ird;
        ird = int'(bus.iss_rd);
        if (m_haz()) return 1'b0;
        if (bus.iss_we && ird != 0 && m_pend[ird] == PMAX) return 1'b0;
        return 1'b1;
    endfunction

    // Applies the effect of the currently driven inputs, as the next clock
    // edge will.
    task automatic model_commit();
        bit acc;
        int n;
        if (rst) begin
            for (int r = 0; r < NR; r++) begin
                m_gpr[r]  = 32'h0;
                m_pend[r] = 0;
            end
        end else begin
            acc = bus.iss_valid && m_ready();
            for (int r = 1; r < NR; r++) begin
                n = m_pend[r];
                if (acc && bus.iss_we && int'(bus.iss_rd) == r) n = n + 1;
                if (wb_to(r)) n = n - 1;
                if (n < 0) n = 0;
                m_pend[r] = n;
            end
            if (wb_to(int'(bus.ruu_rd))) m_gpr[int'(bus.ruu_rd)] = bus.ruu_rdata;
        end
    endtask

    initial begin
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);

        //        chk rst rwe rd rdata         rs1 rs2 iv iwe ird  e_rs1 / e_rs2 / haz / rdy
        vt.push_back(mk(0, 1, 0, 0, 32'h0,        0,  0, 0, 0, 0,  32'h0, 32'h0, 0, 1));
        vt.push_back(mk(1, 0, 0, 0, 32'h0,        5,  0, 0, 0, 0,  32'h0, 32'h0, 0, 1));
        vt.push_back(mk(1, 0, 1, 3, 32'hDEADBEEF, 3,  0, 0, 0, 0,  c_BYP ? 32'hDEADBEEF : 32'h0, 32'h0, 0, 1));
        vt.push_back(mk(1, 0, 1, 0, 32'h12345678, 3,  0, 0, 0, 0,  32'hDEADBEEF, 32'h0, 0, 1));
        vt.push_back(mk(1, 0, 0, 0, 32'h0,        0,  3, 0, 0, 0,  32'h0, 32'hDEADBEEF, 0, 1));
        vt.push_back(mk(1, 0, 0, 0, 32'h0,        0,  0, 1, 1, 7,  32'h0, 32'h0, 0, 1));
        vt.push_back(mk(1, 0, 0, 0, 32'h0,        0,  7, 1, 1, 8,  32'h0, 32'h0, 1, 0));
        vt.push_back(mk(1, 0, 1, 7, 32'h77,       0,  7, 0, 0, 0,  32'h0, c_BYP ? 32'h77 : 32'h0, !c_BYP, c_BYP));
        vt.push_back(mk(1, 0, 0, 0, 32'h0,        8,  7, 0, 0, 0,  32'h0, 32'h77, 0, 1));
        vt.push_back(mk(1, 0, 0, 0, 32'h0,        0,  0, 1, 1, 9,  32'h0, 32'h0, 0, 1));
        vt.push_back(mk(1, 0, 0, 0, 32'h0,        0,  0, 1, 1, 9,  32'h0, 32'h0, 0, 1));
        vt.push_back(mk(1, 0, 0, 0, 32'h0,        0,  0, 1, 1, 9,  32'h0, 32'h0, 0, 1));
        vt.push_back(mk(1, 0, 0, 0, 32'h0,        0,  0, 1, 1, 9,  32'h0, 32'h0, 0, 0));
        vt.push_back(mk(1, 0, 1, 9, 32'h99,       0,  0, 1, 1, 9,  32'h0, 32'h0, 0, 0));
        vt.push_back(mk(1, 0, 0, 0, 32'h0,        0,  0, 1, 1, 9,  32'h0, 32'h0, 0, 1));
        vt.push_back(mk(1, 0, 0, 0, 32'h0,        0,  0, 1, 0, 9,  32'h0, 32'h0, 0, 1));
        vt.push_back(mk(1, 0, 0, 0, 32'h0,        0,  0, 1, 1, 4,  32'h0, 32'h0, 0, 1));
        vt.push_back(mk(1, 0, 1, 4, 32'h44,       0,  0, 1, 1, 4,  32'h0, 32'h0, 0, 1));
        vt.push_back(mk(1, 0, 0, 0, 32'h0,        4,  0, 0, 0, 0,  32'h44, 32'h0, 1, 0));
        vt.push_back(mk(1, 0, 1, 4, 32'h45,       0,  0, 0, 0, 0,  32'h0, 32'h0, 0, 1));
        vt.push_back(mk(1, 0, 0, 0, 32'h0,        4,  0, 0, 0, 0,  32'h45, 32'h0, 0, 1));
        vt.push_back(mk(1, 0, 0, 0, 32'h0,        0,  0, 1, 1, 6,  32'h0, 32'h0, 0, 1));
        vt.push_back(mk(1, 0, 1, 6, 32'h55,       6,  0, 0, 0, 0,  c_BYP ? 32'h55 : 32'h0, 32'h0, !c_BYP, c_BYP));
        vt.push_back(mk(1, 0, 0, 0, 32'h0,        6,  0, 0, 0, 0,  32'h55, 32'h0, 0, 1));
        vt.push_back(mk(1, 0, 1, 10, 32'hA0,      0,  0, 0, 0, 0,  32'h0, 32'h0, 0, 1));
        vt.push_back(mk(1, 0, 0, 0, 32'h0,        10, 0, 0, 0, 0,  32'hA0, 32'h0, 0, 1));
        vt.push_back(mk(1, 0, 0, 0, 32'h0,        0,  0, 1, 1, 10, 32'h0, 32'h0, 0, 1));
        vt.push_back(mk(1, 0, 0, 0, 32'h0,        0, 10, 0, 0, 0,  32'h0, 32'hA0, 1, 0));
        vt.push_back(mk(1, 1, 1, 12, 32'h12,      0,  0, 1, 1, 11, 32'h0, 32'h0, 0, 1));
        vt.push_back(mk(1, 0, 0, 0, 32'h0,        9,  3, 0, 0, 0,  32'h0, 32'h0, 0, 1));
        vt.push_back(mk(1, 0, 0, 0, 32'h0,        10, 12, 0, 0, 0, 32'h0, 32'h0, 0, 1));
        vt.push_back(mk(1, 0, 0, 0, 32'h0,        11, 4, 1, 1, 0,  32'h0, 32'h0, 0, 1));
        vt.push_back(mk(1, 0, 0, 0, 32'h0,        0,  0, 0, 0, 0,  32'h0, 32'h0, 0, 1));

        foreach (vt[i]) begin
            @(negedge clk);
            drive(vt[i].rst, vt[i].rwe, vt[i].rd, vt[i].rdata, vt[i].rs1, vt[i].rs2,
                  vt[i].iv, vt[i].iwe, vt[i].ird);
            #1;
            if (vt[i].chk) begin
                check($sformatf("v%0d rs1_data", i), bus.rs1_data, vt[i].e_rs1);
                check($sformatf("v%0d rs2_data", i), bus.rs2_data, vt[i].e_rs2);
                check($sformatf("v%0d hazard", i), {31'h0, bus.hazard}, {31'h0, vt[i].e_haz});
                check($sformatf("v%0d iss_ready", i), {31'h0, bus.iss_ready}, {31'h0, vt[i].e_rdy});
            end
            model_commit();
        end

        // Random traffic on a small register window so hazards, saturation
        // and same-register collisions happen often.
        @(negedge clk);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        model_commit();
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            drive(($urandom_range(0, 299) == 0),
                  ($urandom_range(0, 99) < 35),
                  $urandom_range(0, 7),
                  $urandom,
                  $urandom_range(0, 7),
                  $urandom_range(0, 7),
                  ($urandom_range(0, 99) < 70),
                  ($urandom_range(0, 99) < 85),
                  $urandom_range(0, 7));
            #1;
            check($sformatf("r%0d rs1_data", c), bus.rs1_data, m_read(int'(bus.rs1_addr)));
            check($sformatf("r%0d rs2_data", c), bus.rs2_data, m_read(int'(bus.rs2_addr)));
            check($sformatf("r%0d hazard", c), {31'h0, bus.hazard}, {31'h0, m_haz()});
            check($sformatf("r%0d iss_ready", c), {31'h0, bus.iss_ready}, {31'h0, m_ready()});
            model_commit();
        end

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
